// File: rtl/qeciphy_crc_pkg.sv
// ============================================================================
// Package  : qeciphy_crc_pkg
// Brief    : CRC-16/IBM-3740 constants, word-update function and checker FSM
//            states, shared between the TX generator and the RX checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package qeciphy_crc_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRCW = 2'd2
  } crc_state_t;

  // Folds one 64-bit word into the CRC, MSB byte first, MSB bit first, unreflected.
  function automatic logic [15:0] crc16_ibm3740_next(input logic [15:0] crc16,
                                                      input logic [63:0] data64);
    logic [15:0] c;
    logic        fb;
    c = crc16;
    for (int i = 63; i >= 0; i--) begin
      fb = c[15] ^ data64[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC16_POLY;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qeciphy_sat_counter.sv
// ============================================================================
// Module   : qeciphy_sat_counter
// Brief    : Saturating up-counter; clear has priority over increment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module qeciphy_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/qeciphy_crc16_ibm3740_checker.sv
// ============================================================================
// Module   : qeciphy_crc16_ibm3740_checker
// Brief    : RX CRC-16/IBM-3740 frame checker with data pass-through and a
//            saturating error counter. Optional macro QECIPHY_CRC_CHECK_PIPE_EN
//            adds a register stage ahead of the compare (all outputs +1 cycle).
// Revision : 1.0
// ============================================================================
`default_nettype none

module qeciphy_crc16_ibm3740_checker
  import qeciphy_crc_pkg::*;
#(
  parameter int FRAME_WORDS = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [63:0]          tdata_i,
  input  logic                 tvalid_i,
  input  logic                 frame_start_i,
  input  logic                 clear_count_i,
  output logic [63:0]          tdata_o,
  output logic                 tvalid_o,
  output logic                 crc_ok_o,
  output logic                 crc_err_o,
  output logic                 frame_abort_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int              CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_WORDS - 1);

  crc_state_t       r_state, w_state_nxt;
  logic [15:0]      r_crc, w_crc_nxt, w_crc_upd, w_crc_seed;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_pass_vld, w_chk_vld, w_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_pass_vld  = 1'b0;
    w_chk_vld   = 1'b0;
    w_abort     = 1'b0;
    w_crc_upd   = crc16_ibm3740_next(r_crc, tdata_i);
    w_crc_seed  = crc16_ibm3740_next(CRC16_INIT, tdata_i);
    if (tvalid_i) begin
      // A start word always opens a new frame, even where a CRC word was due.
      if (frame_start_i) begin
        w_abort    = (r_state != IDLE);
        w_pass_vld = 1'b1;
        w_crc_nxt  = w_crc_seed;
        if (FRAME_WORDS == 1) begin
          w_state_nxt = CRCW;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = DATA;
          w_cnt_nxt   = CNT_W'(1);
        end
      end else begin
        case (r_state)
          DATA: begin
            w_pass_vld = 1'b1;
            w_crc_nxt  = w_crc_upd;
            if (r_cnt == C_LAST) begin
              w_state_nxt = CRCW;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          CRCW: begin
            w_chk_vld   = 1'b1;
            w_state_nxt = IDLE;
            w_crc_nxt   = CRC16_INIT;
            w_cnt_nxt   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_crc   <= CRC16_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_crc   <= w_crc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  logic        w_cmp_vld, w_cmp_abort, w_cmp_dvld;
  logic [15:0] w_cmp_calc, w_cmp_rx;
  logic [63:0] w_cmp_data;

`ifdef QECIPHY_CRC_CHECK_PIPE_EN
  logic        r_p_vld, r_p_abort, r_p_dvld;
  logic [15:0] r_p_calc, r_p_rx;
  logic [63:0] r_p_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p_vld   <= 1'b0;
      r_p_abort <= 1'b0;
      r_p_dvld  <= 1'b0;
      r_p_calc  <= '0;
      r_p_rx    <= '0;
      r_p_data  <= '0;
    end else begin
      r_p_vld   <= w_chk_vld;
      r_p_abort <= w_abort;
      r_p_dvld  <= w_pass_vld;
      r_p_calc  <= r_crc;
      r_p_rx    <= tdata_i[15:0];
      r_p_data  <= tdata_i;
    end
  end

  assign w_cmp_vld   = r_p_vld;
  assign w_cmp_abort = r_p_abort;
  assign w_cmp_dvld  = r_p_dvld;
  assign w_cmp_calc  = r_p_calc;
  assign w_cmp_rx    = r_p_rx;
  assign w_cmp_data  = r_p_data;
`else
  assign w_cmp_vld   = w_chk_vld;
  assign w_cmp_abort = w_abort;
  assign w_cmp_dvld  = w_pass_vld;
  assign w_cmp_calc  = r_crc;
  assign w_cmp_rx    = tdata_i[15:0];
  assign w_cmp_data  = tdata_i;
`endif

  logic        w_mismatch;
  logic        r_ok, r_err, r_abort, r_tvalid;
  logic [63:0] r_tdata;

  assign w_mismatch = w_cmp_vld && (w_cmp_calc != w_cmp_rx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      r_abort  <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_ok     <= w_cmp_vld && !w_mismatch;
      r_err    <= w_mismatch;
      r_abort  <= w_cmp_abort;
      r_tvalid <= w_cmp_dvld;
      if (w_cmp_dvld) r_tdata <= w_cmp_data;
    end
  end

  // Counter updates on the same edge that registers the result pulses.
  qeciphy_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_inc   (w_mismatch || w_cmp_abort),
    .i_clr   (clear_count_i),
    .o_count (err_count_o)
  );

  assign tdata_o       = r_tdata;
  assign tvalid_o      = r_tvalid;
  assign crc_ok_o      = r_ok;
  assign crc_err_o     = r_err;
  assign frame_abort_o = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_qeciphy_crc16_ibm3740_checker.sv
// ============================================================================
// Module   : tb_qeciphy_crc16_ibm3740_checker
// Brief    : Randomized self-checking bench for the CRC-16/IBM-3740 checker,
//            using a polynomial-division reference and a frame-list model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_qeciphy_crc16_ibm3740_checker;

  localparam int FW        = 4;
  localparam int ERR_CNT_W = 2;
  localparam int MAXC      = (1 << ERR_CNT_W) - 1;
`ifdef QECIPHY_CRC_CHECK_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk;
  logic                 rst_i, tvalid_i, frame_start_i, clear_count_i;
  logic [63:0]          tdata_i;
  logic [63:0]          tdata_o;
  logic                 tvalid_o, crc_ok_o, crc_err_o, frame_abort_o;
  logic [ERR_CNT_W-1:0] err_count_o;

  qeciphy_crc16_ibm3740_checker #(
    .FRAME_WORDS (FW),
    .ERR_CNT_W   (ERR_CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .tdata_i       (tdata_i),
    .tvalid_i      (tvalid_i),
    .frame_start_i (frame_start_i),
    .clear_count_i (clear_count_i),
    .tdata_o       (tdata_o),
    .tvalid_o      (tvalid_o),
    .crc_ok_o      (crc_ok_o),
    .crc_err_o     (crc_err_o),
    .frame_abort_o (frame_abort_o),
    .err_count_o   (err_count_o)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          e        = 0;
  int          cnt_m    = 0;
  int          n_ok = 0, n_err = 0, n_ab = 0, n_words = 0;
  int          last_ok_edge = -1, crc_edge = -1;
  logic [63:0] last_d = '0;
  logic [63:0] frame[$];
  bit          exp_ok[int], exp_err[int], exp_ab[int], exp_inc[int], exp_dv[int];
  logic [63:0] exp_d[int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Remainder of (message * x^16) mod P with the init folded into the first 16 bits.
  function automatic logic [15:0] ref_crc(input bq_t q);
    logic        bits[$];
    logic [16:0] r;
    foreach (q[i]) for (int b = 7; b >= 0; b--) bits.push_back(q[i][b]);
    for (int i = 0; i < 16; i++) bits[i] = ~bits[i];
    repeat (16) bits.push_back(1'b0);
    r = '0;
    foreach (bits[i]) begin
      r = {r[15:0], bits[i]};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] frame_crc(input logic [63:0] w[$]);
    bq_t q;
    foreach (w[i]) for (int k = 7; k >= 0; k--) q.push_back(w[i][8*k +: 8]);
    return ref_crc(q);
  endfunction

  task automatic model_step();
    int t;
    t = e + LAT - 1;
    if (rst_i) begin
      frame.delete();
      exp_ok.delete(); exp_err.delete(); exp_ab.delete();
      exp_inc.delete(); exp_dv.delete(); exp_d.delete();
      cnt_m = 0;
      return;
    end
    if (tvalid_i) begin
      if (frame_start_i) begin
        if (frame.size() > 0) begin
          exp_ab[t]  = 1'b1;
          exp_inc[t] = 1'b1;
        end
        frame.delete();
        frame.push_back(tdata_i);
        exp_dv[t] = 1'b1;
        exp_d[t]  = tdata_i;
      end else if (frame.size() == FW) begin
        if (frame_crc(frame) == tdata_i[15:0]) exp_ok[t] = 1'b1;
        else begin
          exp_err[t] = 1'b1;
          exp_inc[t] = 1'b1;
        end
        frame.delete();
        crc_edge = e;
      end else if (frame.size() > 0) begin
        frame.push_back(tdata_i);
        exp_dv[t] = 1'b1;
        exp_d[t]  = tdata_i;
      end
    end
    if (clear_count_i) cnt_m = 0;
    else if (exp_inc.exists(e) && cnt_m < MAXC) cnt_m++;
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    model_step();
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input bit st, input bit v);
    tdata_i       = d;
    frame_start_i = st;
    tvalid_i      = v;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic gap(input int gmax);
    if (gmax > 0) idle($urandom_range(0, gmax));
  endtask

  // Sends a full frame; corrupt flips bit 0 of data word 2 after the CRC is formed.
  task automatic send_frame(input bit corrupt, input int gmax);
    logic [63:0] w[$];
    logic [63:0] cw;
    for (int i = 0; i < FW; i++) w.push_back({$urandom, $urandom});
    cw        = {$urandom, $urandom};
    cw[15:0]  = frame_crc(w);
    if (corrupt) w[2][0] = ~w[2][0];
    for (int i = 0; i < FW; i++) begin
      gap(gmax);
      drive(w[i], i == 0, 1'b1);
    end
    gap(gmax);
    drive(cw, 1'b0, 1'b1);
  endtask

  task automatic send_partial(input int k);
    for (int i = 0; i < k; i++) drive({$urandom, $urandom}, i == 0, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        last_d = '0;
      end else begin
        if (exp_dv.exists(e)) last_d = exp_d[e];
        check("crc_ok", crc_ok_o, exp_ok.exists(e));
        check("crc_err", crc_err_o, exp_err.exists(e));
        check("frame_abort", frame_abort_o, exp_ab.exists(e));
        check("tvalid_o", tvalid_o, exp_dv.exists(e));
        check("tdata_o", tdata_o, last_d);
        check("err_count", err_count_o, cnt_m);
        if (crc_ok_o) begin n_ok++; last_ok_edge = e; end
        if (crc_err_o) n_err++;
        if (frame_abort_o) n_ab++;
        if (tvalid_o) n_words++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  ok0, err0, ab0, w0;

    rst_i = 1'b1; tvalid_i = 1'b0; frame_start_i = 1'b0;
    clear_count_i = 1'b0; tdata_i = '0;

    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("ref_check_value", ref_crc(q), 16'h29B1);

    tick(); tick();
    check("rst_err_count", err_count_o, 0);
    check("rst_crc_ok", crc_ok_o, 0);
    check("rst_tvalid", tvalid_o, 0);
    check("rst_tdata", tdata_o, 0);
    rst_i = 1'b0;
    idle(2);

    // Stray valid words outside a frame are dropped.
    for (int i = 0; i < 3; i++) drive({$urandom, $urandom}, 1'b0, 1'b1);
    idle(LAT + 1);
    check("stray_no_words", n_words, 0);

    ok0 = n_ok; w0 = n_words;
    send_frame(1'b0, 0);
    idle(LAT + 1);
    check("clean_ok", n_ok - ok0, 1);
    check("clean_words", n_words - w0, FW);
    check("clean_latency", last_ok_edge - crc_edge, LAT - 1);
    check("clean_count", err_count_o, 0);

    send_frame(1'b1, 0);
    idle(LAT + 1);
    check("bad_err", n_err, 1);
    check("bad_count", err_count_o, 1);
    send_frame(1'b0, 0);
    idle(LAT + 1);
    check("after_bad_count", err_count_o, 1);

    ok0 = n_ok;
    send_partial(2);
    send_frame(1'b0, 0);
    idle(LAT + 1);
    check("abort_pulse", n_ab, 1);
    check("abort_count", err_count_o, 2);
    check("abort_restart_ok", n_ok - ok0, 1);

    clear_count_i = 1'b1; idle(1); clear_count_i = 1'b0; idle(1);
    check("clear_count", err_count_o, 0);

    ok0 = n_ok; err0 = n_err; ab0 = n_ab;
    for (int i = 0; i < 10; i++) send_frame(1'b0, (i % 3 == 0) ? 0 : 2);
    idle(LAT + 1);
    check("b2b_ok", n_ok - ok0, 10);
    check("b2b_err", (n_err - err0) + (n_ab - ab0), 0);

    for (int i = 0; i < 5; i++) send_frame(1'b1, 1);
    idle(LAT + 1);
    check("saturate", err_count_o, MAXC);
    clear_count_i = 1'b1;
    send_frame(1'b1, 0);
    idle(LAT + 1);
    clear_count_i = 1'b0;
    idle(1);
    check("clear_wins", err_count_o, 0);

    ok0 = n_ok; err0 = n_err; ab0 = n_ab;
    send_partial(2);
    rst_i = 1'b1; tvalid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    idle(2);
    send_frame(1'b0, 0);
    idle(LAT + 1);
    check("rst_mid_ok", n_ok - ok0, 1);
    check("rst_mid_no_err", (n_err - err0) + (n_ab - ab0), 0);
    check("rst_mid_latency", last_ok_edge - crc_edge, LAT - 1);

    // Mixed random traffic: corruption and aborts, including in the CRC slot.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) send_partial($urandom_range(1, FW));
      send_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) clear_count_i = 1'b1;
      idle($urandom_range(0, 1));
      clear_count_i = 1'b0;
    end
    idle(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
